// File: rtl/mem_arb_pkg.sv
// mem_arb shared types and constants.
// State encodings, access/length codes, bus widths.
package mem_arb_pkg;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic LD = 1'b0;
  localparam logic ST = 1'b1;

  localparam logic [1:0] IO_HI = 2'b11;

  localparam logic [2:0] LEN1 = 3'd1;
  localparam logic [2:0] LEN2 = 3'd2;
  localparam logic [2:0] LEN4 = 3'd4;

  function automatic logic [DW-1:0] zext(
    input logic [DW-1:0] d,
    input logic [2:0]    len
  );
    logic [DW-1:0] r;
    r = d;
    if (len == LEN1)
      r = {{(DW-8){1'b0}}, d[7:0]};
    else if (len == LEN2)
      r = {{(DW-16){1'b0}}, d[15:0]};
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb grant selection.
// LS beats IF unless IF is starved or the LS store hits a full IO buffer.
module mem_arb_pick #(
  parameter int         STARVE_MAX = 4,
  parameter logic [1:0] IO_HI      = mem_arb_pkg::IO_HI,
  parameter int         CW         = 3
) (
  input  logic          open,
  input  logic          if_req,
  input  logic          ls_req,
  input  logic          ls_st,
  input  logic [1:0]    ls_seg,
  input  logic          io_full,
  input  logic [CW-1:0] cnt,
  output logic          grant_if,
  output logic          grant_ls
);

  logic ls_ok;
  logic starve;

  // priority with starvation override and IO-store stall
  always_comb begin
    ls_ok    = ls_req & ~(ls_st & (ls_seg == IO_HI) & io_full);
    starve   = if_req & (cnt == CW'(STARVE_MAX));
    grant_ls = open & ls_ok & ~starve;
    grant_if = open & if_req & ~grant_ls;
  end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: arbitrates memctrl between fetch and the load/store buffer.
// One access outstanding; cancelled fetches drain before the next grant.
module mem_arb #(
  parameter int         STARVE_MAX = 4,
  parameter logic [1:0] IO_HI      = mem_arb_pkg::IO_HI
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        iIO_buffer_full,
  input  logic        iCLR,
  input  logic        iIF_en,
  input  logic [31:0] iIF_addr,
  output logic        oIF_done,
  output logic [31:0] oIF_inst,
  input  logic        iLS_en,
  input  logic        iLS_ls,
  input  logic [2:0]  iLS_len,
  input  logic [31:0] iLS_addr,
  input  logic [31:0] iLS_dt,
  output logic        oLS_done,
  output logic [31:0] oLS_dt,
  output logic        oMC_en,
  output logic        oMC_ls,
  output logic [2:0]  oMC_len,
  output logic [31:0] oMC_addr,
  output logic [31:0] oMC_dt,
  input  logic        iMC_done,
  input  logic [31:0] iMC_dt
);

  import mem_arb_pkg::*;

  localparam int CW = $clog2(STARVE_MAX + 1);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic          open;
  logic          grant_if;
  logic          grant_ls;

  assign open = rdy & (state == IDLE) & ~iCLR;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .IO_HI      (IO_HI),
    .CW         (CW)
  ) u_pick (
    .open     (open),
    .if_req   (iIF_en),
    .ls_req   (iLS_en),
    .ls_st    (iLS_ls),
    .ls_seg   (iLS_addr[17:16]),
    .io_full  (iIO_buffer_full),
    .cnt      (cnt),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  // next state; frozen while rdy is low
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (grant_ls)
          state_n = BUSY_LS;
        else if (grant_if)
          state_n = BUSY_IF;
      end
      BUSY_IF: begin
        if (iMC_done)
          state_n = IDLE;
        else if (iCLR)
          state_n = DRAIN;
      end
      BUSY_LS, DRAIN: begin
        if (iMC_done)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (!rdy)
      state_n = state;
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  // consecutive LS grants while fetch waits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (rdy && state == IDLE) begin
      if (!iIF_en || grant_if)
        cnt <= '0;
      else if (grant_ls && cnt != CW'(STARVE_MAX))
        cnt <= cnt + 1'b1;
    end
  end

  // launch pulse and payload, held until the next grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oMC_en   <= 1'b0;
      oMC_ls   <= 1'b0;
      oMC_len  <= 3'd0;
      oMC_addr <= '0;
      oMC_dt   <= '0;
    end else if (rdy) begin
      oMC_en <= grant_if | grant_ls;
      if (grant_ls) begin
        oMC_ls   <= iLS_ls;
        oMC_len  <= iLS_len;
        oMC_addr <= iLS_addr;
        oMC_dt   <= iLS_dt;
      end else if (grant_if) begin
        oMC_ls   <= LD;
        oMC_len  <= LEN4;
        oMC_addr <= iIF_addr;
        oMC_dt   <= '0;
      end
    end
  end

  // completion routed back in the same cycle as memctrl done
  always_comb begin
    oIF_done = rdy & (state == BUSY_IF) & iMC_done & ~iCLR;
    oIF_inst = oIF_done ? iMC_dt : '0;
    oLS_done = rdy & (state == BUSY_LS) & iMC_done;
    oLS_dt   = (oLS_done && oMC_ls == LD) ? zext(iMC_dt, oMC_len) : '0;
  end

endmodule

// File: tb/tb_mem_arb.sv
// mem_arb bench: vector table, directed corner sequences,
// then random traffic against a transaction-level reference model.
module tb_mem_arb;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, io_full, clr;
  logic        if_en;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;
  logic        ls_en, ls_ls;
  logic [2:0]  ls_len;
  logic [31:0] ls_addr, ls_dt;
  logic        ls_done;
  logic [31:0] ls_rdt;
  logic        mc_en, mc_ls;
  logic [2:0]  mc_len;
  logic [31:0] mc_addr, mc_wdt;
  logic        mc_done;
  logic [31:0] mc_dt;

  int checks = 0;
  int failures = 0;

  mem_arb dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .iIO_buffer_full(io_full), .iCLR(clr),
    .iIF_en(if_en), .iIF_addr(if_addr),
    .oIF_done(if_done), .oIF_inst(if_inst),
    .iLS_en(ls_en), .iLS_ls(ls_ls), .iLS_len(ls_len),
    .iLS_addr(ls_addr), .iLS_dt(ls_dt),
    .oLS_done(ls_done), .oLS_dt(ls_rdt),
    .oMC_en(mc_en), .oMC_ls(mc_ls), .oMC_len(mc_len),
    .oMC_addr(mc_addr), .oMC_dt(mc_wdt),
    .iMC_done(mc_done), .iMC_dt(mc_dt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // launched payload seen by the bench
  logic [31:0] l_addr, l_dt;
  logic        l_ls;
  logic [2:0]  l_len;
  // sampled completion
  logic        s_ifd, s_lsd;
  logic [31:0] s_inst, s_lsdt;

  task automatic wait_launch(input string name);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (mc_en) begin
        ok = 1;
        l_addr = mc_addr; l_ls = mc_ls;
        l_len = mc_len; l_dt = mc_wdt;
      end
    end
    if (!ok) begin
      chk({name, "_launch_timeout"}, 0, 1);
      l_addr = 'x; l_ls = 'x; l_len = 'x; l_dt = 'x;
    end
  endtask

  // call at a negedge: done for one cycle, return at next negedge
  task automatic complete(input logic [31:0] dt);
    mc_done = 1'b1; mc_dt = dt;
    #1;
    s_ifd = if_done; s_inst = if_inst;
    s_lsd = ls_done; s_lsdt = ls_rdt;
    @(negedge clk);
    mc_done = 1'b0; mc_dt = '0;
  endtask

  task automatic serve(input string name, input logic [31:0] dt);
    wait_launch(name);
    @(negedge clk);
    chk({name, "_en_pulse"}, mc_en, 0);
    complete(dt);
  endtask

  task automatic quiet();
    if_en = 0; ls_en = 0; clr = 0; mc_done = 0;
    io_full = 0; rdy = 1; mc_dt = '0;
  endtask

  typedef struct {
    logic        ife;
    logic [31:0] ifa;
    logic        lse;
    logic        lsl;
    logic [31:0] lsa;
    logic        full;
    int          kind; // 0 none, 1 fetch, 2 load/store
  } vec_t;

  vec_t vt[9];

  // reference model state (random phase)
  int          m_kind;   // 0 none, 1 fetch, 2 data, 3 cancelled
  int          m_streak;
  logic        m_en, m_ls;
  logic [2:0]  m_len;
  logic [31:0] m_addr, m_wdt;
  bit          mc_act;
  int          mc_cnt;

  function automatic logic [31:0] narrow(input logic [31:0] d,
                                         input logic [2:0] n);
    if (n == 3'd1) return d % 256;
    if (n == 3'd2) return d % 65536;
    return d;
  endfunction

  initial begin
    vt[0] = '{1, 32'h100, 0, 0, 32'h0,     0, 1};
    vt[1] = '{0, 32'h0,   1, 0, 32'h2000,  0, 2};
    vt[2] = '{1, 32'h104, 1, 0, 32'h2008,  0, 2};
    vt[3] = '{1, 32'h108, 1, 1, 32'h30000, 1, 1};
    vt[4] = '{1, 32'h10C, 1, 1, 32'h30004, 0, 2};
    vt[5] = '{0, 32'h0,   1, 1, 32'h30008, 1, 0};
    vt[6] = '{0, 32'h0,   1, 0, 32'h3000C, 1, 2};
    vt[7] = '{0, 32'h0,   0, 0, 32'h0,     0, 0};
    vt[8] = '{1, 32'h110, 1, 1, 32'h20000, 1, 2};

    quiet();
    rst = 0; if_addr = 0; ls_ls = 0; ls_len = 4;
    ls_addr = 0; ls_dt = 0;
    @(negedge clk);
    mc_done = 1; mc_dt = 32'hFFFF_FFFF;
    #1;
    chk("rst_mc_en", mc_en, 0);
    chk("rst_mc_addr", mc_addr, 0);
    chk("rst_mc_len", mc_len, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_ls_done", ls_done, 0);
    @(negedge clk);
    mc_done = 0; rst = 1;
    @(negedge clk);

    // single-grant vectors from an idle, cleared arbiter
    for (int i = 0; i < 9; i++) begin
      if_en = vt[i].ife; if_addr = vt[i].ifa;
      ls_en = vt[i].lse; ls_ls = vt[i].lsl;
      ls_addr = vt[i].lsa; ls_len = 4;
      ls_dt = 32'hCAFE_0000 + i;
      io_full = vt[i].full;
      @(negedge clk);
      chk($sformatf("vec%0d_en", i), mc_en, vt[i].kind != 0);
      if (vt[i].kind == 1)
        chk($sformatf("vec%0d_addr", i), mc_addr, vt[i].ifa);
      if (vt[i].kind == 2)
        chk($sformatf("vec%0d_addr", i), mc_addr, vt[i].lsa);
      mc_done = 1; mc_dt = 32'h1122_3344;
      #1;
      chk($sformatf("vec%0d_ifd", i), if_done, vt[i].kind == 1);
      chk($sformatf("vec%0d_lsd", i), ls_done, vt[i].kind == 2);
      @(negedge clk);
      quiet();
      @(negedge clk);
    end

    // fetch only
    if_en = 1; if_addr = 32'h100;
    serve("fetch", 32'h00A0_0093);
    if_en = 0;
    chk("fetch_addr", l_addr, 32'h100);
    chk("fetch_len", l_len, 4);
    chk("fetch_ls", l_ls, 0);
    chk("fetch_done", s_ifd, 1);
    chk("fetch_inst", s_inst, 32'h00A0_0093);
    chk("fetch_idle", dut.state == IDLE, 1);

    // both pending: LS first, then IF
    if_en = 1; if_addr = 32'h100;
    ls_en = 1; ls_ls = 0; ls_len = 2; ls_addr = 32'h2000;
    serve("both_ls", 32'hDEAD_BEEF);
    ls_en = 0;
    chk("both_ls_addr", l_addr, 32'h2000);
    chk("both_ls_len", l_len, 2);
    chk("both_ls_done", s_lsd, 1);
    chk("both_ls_dt", s_lsdt, 32'h0000_BEEF);
    chk("both_ls_ifd", s_ifd, 0);
    serve("both_if", 32'h0000_0013);
    if_en = 0;
    chk("both_if_addr", l_addr, 32'h100);
    chk("both_if_done", s_ifd, 1);

    // starvation: four LS grants, fifth goes to IF
    if_en = 1; ls_en = 1;
    for (int k = 0; k < 5; k++) begin
      serve($sformatf("starve%0d", k), 32'h1234_5678);
      chk($sformatf("starve%0d_addr", k), l_addr,
          k < 4 ? 32'h2000 : 32'h100);
    end
    if_en = 0; ls_en = 0;
    @(negedge clk);

    // IO store stalled by full buffer
    io_full = 1;
    ls_en = 1; ls_ls = 1; ls_len = 1;
    ls_addr = 32'h30000; ls_dt = 32'h55;
    if_en = 1; if_addr = 32'h400;
    serve("io_if", 32'h0);
    if_en = 0;
    chk("io_if_addr", l_addr, 32'h400);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("io_stall%0d", k), mc_en, 0);
    end
    io_full = 0;
    serve("io_st", 32'hFFFF_FFFF);
    ls_en = 0;
    chk("io_st_addr", l_addr, 32'h30000);
    chk("io_st_ls", l_ls, 1);
    chk("io_st_dt", l_dt, 32'h55);
    chk("io_st_done", s_lsd, 1);
    chk("io_st_rdt", s_lsdt, 0);

    // clear during fetch: drain, then refetch
    if_en = 1; if_addr = 32'h100;
    wait_launch("drain");
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0; if_addr = 32'h200;
    chk("drain_state", dut.state == DRAIN, 1);
    @(negedge clk);
    chk("drain_block", mc_en, 0);
    complete(32'hAAAA_AAAA);
    chk("drain_ifd", s_ifd, 0);
    chk("drain_inst", s_inst, 0);
    serve("refetch", 32'h0000_0073);
    if_en = 0;
    chk("refetch_addr", l_addr, 32'h200);
    chk("refetch_done", s_ifd, 1);

    // clear coincident with fetch done
    if_en = 1; if_addr = 32'h180;
    wait_launch("clrdone");
    @(negedge clk);
    clr = 1;
    complete(32'hBBBB_BBBB);
    clr = 0; if_en = 0;
    chk("clrdone_ifd", s_ifd, 0);
    chk("clrdone_idle", dut.state == IDLE, 1);

    // clear during a store does not cancel it
    ls_en = 1; ls_ls = 1; ls_len = 4;
    ls_addr = 32'h1000; ls_dt = 32'h1234;
    wait_launch("st_clr");
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
    complete(32'h0);
    ls_en = 0;
    chk("st_clr_done", s_lsd, 1);

    // rdy low freezes BUSY_LS and masks done
    ls_en = 1; ls_ls = 0; ls_len = 4; ls_addr = 32'h2004;
    wait_launch("rdy");
    @(negedge clk);
    rdy = 0; mc_done = 1; mc_dt = 32'h8765_4321;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("rdy_lsd%0d", k), ls_done, 0);
      @(negedge clk);
      chk($sformatf("rdy_state%0d", k), dut.state == BUSY_LS, 1);
      chk($sformatf("rdy_addr%0d", k), mc_addr, 32'h2004);
    end
    rdy = 1;
    #1;
    chk("rdy_lsd_on", ls_done, 1);
    chk("rdy_lsdt_on", ls_rdt, 32'h8765_4321);
    @(negedge clk);
    mc_done = 0; ls_en = 0;

    // reset mid-fetch abandons it
    if_en = 1; if_addr = 32'h300;
    wait_launch("rstmid");
    @(negedge clk);
    mc_done = 1; mc_dt = 32'h5555_5555;
    rst = 0;
    #1;
    chk("rstmid_en", mc_en, 0);
    chk("rstmid_addr", mc_addr, 0);
    chk("rstmid_len", mc_len, 0);
    chk("rstmid_ifd", if_done, 0);
    chk("rstmid_inst", if_inst, 0);
    if_en = 0; mc_done = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rstmid_idle", dut.state == IDLE, 1);

    // random traffic against the reference model
    quiet();
    m_kind = 0; m_streak = 0; m_en = 0; m_ls = 0;
    m_len = 0; m_addr = 0; m_wdt = 0;
    mc_act = 0; mc_cnt = 0;
    rst = 0;
    @(negedge clk);
    rst = 1;
    begin
      bit drop_if = 0, drop_ls = 0;
      for (int c = 0; c < 3000; c++) begin
        logic e_ifd, e_lsd, ls_ok;
        logic [31:0] e_inst, e_lsdt;
        int win;
        @(negedge clk);
        if (drop_if) if_en = 0;
        if (drop_ls) ls_en = 0;
        drop_if = 0; drop_ls = 0;
        rdy = $urandom_range(0, 9) != 0;
        clr = $urandom_range(0, 19) == 0;
        if ($urandom_range(0, 7) == 0) io_full = ~io_full;
        if (!if_en && $urandom_range(0, 2) == 0) begin
          if_en = 1; if_addr = $urandom & 32'hFFFF_FFFC;
        end else if (if_en && clr) begin
          if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!ls_en && $urandom_range(0, 1) == 0) begin
          int s = $urandom_range(0, 2);
          ls_en = 1; ls_ls = $urandom_range(0, 1);
          ls_len = s == 0 ? 3'd1 : s == 1 ? 3'd2 : 3'd4;
          ls_addr = $urandom;
          ls_addr[17:16] = $urandom_range(0, 1) ? 2'b11 : 2'(ls_addr[17:16]);
          ls_dt = $urandom;
        end
        mc_done = mc_act && mc_cnt == 0;
        mc_dt = $urandom;
        #1;
        e_ifd = rdy && m_kind == 1 && mc_done && !clr;
        e_inst = e_ifd ? mc_dt : 32'h0;
        e_lsd = rdy && m_kind == 2 && mc_done;
        e_lsdt = (e_lsd && !m_ls) ? narrow(mc_dt, m_len) : 32'h0;
        chk("r_mc_en", mc_en, m_en);
        chk("r_mc_addr", mc_addr, m_addr);
        chk("r_mc_ls", mc_ls, m_ls);
        chk("r_mc_len", mc_len, m_len);
        chk("r_mc_dt", mc_wdt, m_wdt);
        chk("r_if_done", if_done, e_ifd);
        chk("r_if_inst", if_inst, e_inst);
        chk("r_ls_done", ls_done, e_lsd);
        chk("r_ls_dt", ls_rdt, e_lsdt);
        if (rdy) begin
          win = 0;
          if (m_kind == 0) begin
            ls_ok = ls_en && !(ls_ls && ls_addr[17:16] == 2'b11 && io_full);
            if (!clr) begin
              if (if_en && m_streak >= 4) win = 1;
              else if (ls_ok) win = 2;
              else if (if_en) win = 1;
            end
            if (!if_en || win == 1) m_streak = 0;
            else if (win == 2 && m_streak < 4) m_streak++;
          end else if (mc_done) begin
            m_kind = 0;
          end else if (m_kind == 1 && clr) begin
            m_kind = 3;
          end
          if (mc_done) mc_act = 0;
          else if (mc_act && mc_cnt > 0) mc_cnt--;
          m_en = win != 0;
          if (win != 0) begin
            m_kind = win;
            m_ls   = win == 2 ? ls_ls : 1'b0;
            m_len  = win == 2 ? ls_len : 3'd4;
            m_addr = win == 2 ? ls_addr : if_addr;
            m_wdt  = win == 2 ? ls_dt : 32'h0;
            mc_act = 1; mc_cnt = $urandom_range(1, 4);
          end
          drop_if = e_ifd;
          drop_ls = e_lsd;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbitrates the single byte-serial memory controller between instruction fetch (IF) and the load/store buffer (LSB).
- Sits between those requesters and memctrl: grants one request at a time, launches it, and routes the completion and data back.
- Sequences the resource under mispredict clear, the IO-buffer-full stall and rdy gating.
- Prevents fetch starvation under heavy data traffic.

Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while IF is pending before IF is forced.
- IO_HI, 2'b11: value of addr[17:16] that marks an IO address.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; low freezes all state
- iIO_buffer_full  in  1  IO output buffer full
- iCLR  in  1  mispredict clear (one-cycle pulse)
- iIF_en  in  1  fetch request (level, held until done)
- iIF_addr  in  32  fetch address
- oIF_done  out  1  fetch complete
- oIF_inst  out  32  fetched instruction
- iLS_en  in  1  load/store request (level, held until done)
- iLS_ls  in  1  0 = load, 1 = store
- iLS_len  in  3  byte count: 1, 2 or 4
- iLS_addr  in  32  data address
- iLS_dt  in  32  store data
- oLS_done  out  1  load/store complete
- oLS_dt  out  32  load data, zero-extended
- oMC_en  out  1  launch pulse to memctrl
- oMC_ls  out  1  launched access type
- oMC_len  out  3  launched length (4 for fetch)
- oMC_addr  out  32  launched address
- oMC_dt  out  32  launched store data
- iMC_done  in  1  memctrl completion
- iMC_dt  in  32  memctrl read data

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; starvation counter = 0.
  - oMC_en = 0, oMC_ls = 0, oMC_len = 0, oMC_addr = 0, oMC_dt = 0.
  - oIF_done = 0, oIF_inst = 0, oLS_done = 0, oLS_dt = 0.
  - Reset mid-transaction abandons it; no done is issued.
- rdy = 0: no state, counter or registered-output change.
  - Combinational done outputs are forced to 0.
- States:
  - IDLE: no access outstanding.
  - BUSY_IF: a fetch is outstanding at memctrl.
  - BUSY_LS: a load or store is outstanding at memctrl.
  - DRAIN: a cancelled access is still running in memctrl; its result is discarded.
- IDLE grant (registered):
  - The request is sampled at edge t.
  - oMC_en = 1 for exactly the cycle after t; oMC_ls/len/addr/dt are loaded at t.
  - The payload is held stable until the state leaves BUSY_IF, BUSY_LS or DRAIN.
- Priority:
  - LS wins over IF.
  - If IF is pending and counter == STARVE_MAX, IF wins.
  - Counter behaviour:
    - Increments on each LS grant while iIF_en = 1.
    - Clears on an IF grant.
    - Clears when iIF_en = 0 in IDLE.
    - Saturates at STARVE_MAX.
- IO stall:
  - An LS store with addr[17:16] == IO_HI is ineligible while iIO_buffer_full = 1.
  - IF may be granted instead.
  - An access already outstanding is unaffected.
- No grant in a cycle where iCLR = 1.
  - The LS request is not cleared by the arbiter; the LSB owns its own flush.
- Completion (combinational pass-through, same cycle as iMC_done):
  - BUSY_IF: oIF_done = iMC_done & ~iCLR; oIF_inst = iMC_dt when done, else 0.
  - BUSY_LS: oLS_done = iMC_done; oLS_dt = iMC_dt for loads, 0 for stores.
  - Next state is IDLE.
  - The requester drops en on the edge at which done was seen, so there is no double grant.
- Clear:
  - iCLR in BUSY_IF without iMC_done: go to DRAIN.
  - iCLR in BUSY_IF with iMC_done: done is suppressed; go to IDLE.
  - Stores are never cancelled.
  - iCLR in BUSY_LS: ignored; the LSB discards the result itself.
- DRAIN: no done outputs; go to IDLE on iMC_done; new grants are blocked until then.
- Done outputs are never asserted in IDLE or DRAIN.

Decomposition:
- Shared config header holds:
  - state encodings IDLE, BUSY_IF, BUSY_LS, DRAIN;
  - Load/Store encodings;
  - IO_HI;
  - length codes 1, 2, 4;
  - the 32-bit address and data bus width macros.
- One natural sub-module: mem_arb_pick.
  - Combinational priority and starvation selection.
  - Inputs: requests, IO stall, counter.
  - Outputs: grant_if, grant_ls.

Test Plan:
- Fetch only: iIF_addr = 0x100 held in IDLE → oMC_en pulse, oMC_addr = 0x100, oMC_len = 4; iMC_done with iMC_dt = 0x00A00093 → oIF_done = 1, oIF_inst = 0x00A00093 the same cycle; state IDLE next edge.
- Simultaneous IF and LS load (addr 0x2000, len 2) → LS granted first, oLS_dt = 0x0000BEEF; IF granted next; with LS re-requested 4 times while IF pending, the 5th grant goes to IF.
- IO store to 0x30000 with iIO_buffer_full = 1 and IF pending → IF granted; the store is launched only after iIO_buffer_full drops and the arbiter is IDLE.
- iCLR two cycles after a fetch launch → DRAIN; iMC_done gives oIF_done = 0; the next fetch from 0x200 is launched only after drain completes.
- iCLR coincident with fetch iMC_done → no oIF_done; IDLE next cycle. iCLR during a store → store completes and oLS_done = 1.
- rdy low for 3 cycles mid-BUSY_LS → state and payload frozen. rst asserted in BUSY_IF → all outputs 0 immediately, IDLE after release.
